lfsr_lane_bank: RTL and testbench

//  Parametrised bank of NUM_LANES independent WIDTH-bit Fibonacci LFSRs, one per arrow lane. Replaces the fixed
//  per-lane random generators feeding the VGA renderer. Adds runtime seed loading, zero-lock-up guard, two step

---
 rtl/lfsr_lane_bank_if.sv | 25 ++
 rtl/lfsr_lane_bank.sv | 116 +++++++++++
 tb/tb_lfsr_lane_bank.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_lane_bank_if.sv
// Draw port between spawn logic (master) and the LFSR lane bank (slave):
// a request channel carrying a lane index and a 1-deep response channel.
interface lfsr_lane_bank_if #(
    parameter int WIDTH = 13,
    parameter int LW    = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [LW-1:0]    req_lane;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [LW-1:0]    rsp_lane;
    logic             rsp_err;

    modport master (
        output req_valid, req_lane, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_lane, rsp_err
    );

    modport slave (
        input  req_valid, req_lane, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_lane, rsp_err
    );
endinterface

// File: rtl/lfsr_lane_bank.sv
// Bank of independent Fibonacci LFSRs, one per arrow lane, with runtime seeding,
// tick-driven or draw-driven stepping, and a valid/ready draw port.
module lfsr_lane_bank #(
    parameter int               NUM_LANES   = 4,
    parameter int               WIDTH       = 13,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(13'h100D),
    parameter logic [WIDTH-1:0] SEED_BASE   = WIDTH'(13'h0001),
    parameter logic [WIDTH-1:0] SEED_STRIDE = WIDTH'(13'h0100),
    parameter int               LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       mode,
    input  logic                       seed_we,
    input  logic [LW-1:0]              seed_lane,
    input  logic [WIDTH-1:0]           seed_data,
    lfsr_lane_bank_if.slave            draw,
    output logic [NUM_LANES*WIDTH-1:0] rand_flat
);
    localparam logic [31:0] NUM_LANES_U = 32'(NUM_LANES);

    // An all-zero state would lock the register up, so it steps to 1 instead.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        if (s == '0) begin
            return WIDTH'(1);
        end
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic             accept;
    logic             req_in_range;
    logic [WIDTH-1:0] seed_coerced;
    logic [WIDTH-1:0] rsp_sel;
    logic [WIDTH-1:0] lane_rsp [NUM_LANES];

    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [LW-1:0]    rsp_lane_q;

    assign draw.req_ready = !rsp_valid_q || draw.rsp_ready;
    assign accept         = draw.req_valid && draw.req_ready;
    assign req_in_range   = 32'(draw.req_lane) < NUM_LANES_U;
    assign seed_coerced   = (seed_data == '0) ? WIDTH'(1) : seed_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [WIDTH-1:0] SEED_RAW = SEED_BASE + WIDTH'(gi) * SEED_STRIDE;
            localparam logic [WIDTH-1:0] SEED_RST = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;

            logic             seed_hit;
            logic             draw_hit;
            logic             step_en;
            logic [WIDTH-1:0] state_q;
            logic [WIDTH-1:0] state_d;

            assign seed_hit = seed_we && (seed_lane == LW'(gi));
            assign draw_hit = accept && (draw.req_lane == LW'(gi));
            assign step_en  = mode ? draw_hit : tick;

            always_comb begin
                state_d = state_q;
                if (seed_hit) begin
                    state_d = seed_coerced;
                end else if (step_en) begin
                    state_d = lfsr_step(state_q);
                end
            end

            // Draw-mode and same-cycle seeds report the new state; a free-run draw reports the pre-tick state.
            assign lane_rsp[gi] = (mode || seed_hit) ? state_d : state_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= SEED_RST;
                end else begin
                    state_q <= state_d;
                end
            end

            assign rand_flat[gi*WIDTH +: WIDTH] = state_q;
        end
    endgenerate

    always_comb begin
        rsp_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (draw.req_lane == LW'(i)) begin
                rsp_sel = lane_rsp[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_lane_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= req_in_range ? rsp_sel : '0;
            rsp_lane_q  <= draw.req_lane;
            rsp_err_q   <= !req_in_range;
        end else if (draw.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign draw.rsp_valid = rsp_valid_q;
    assign draw.rsp_data  = rsp_data_q;
    assign draw.rsp_lane  = rsp_lane_q;
    assign draw.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lfsr_lane_bank.sv
// Directed plus random check of the LFSR lane bank against a behavioural model
// and a response scoreboard; lane index is widened so out-of-range draws are reachable.
module tb_lfsr_lane_bank;
    localparam int NL = 4;
    localparam int W  = 13;
    localparam int LW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            tick;
    logic            mode;
    logic            seed_we;
    logic [LW-1:0]   seed_lane;
    logic [W-1:0]    seed_data;
    logic [NL*W-1:0] rand_flat;

    lfsr_lane_bank_if #(.WIDTH(W), .LW(LW)) bus ();

    lfsr_lane_bank #(.NUM_LANES(NL), .WIDTH(W), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .mode      (mode),
        .seed_we   (seed_we),
        .seed_lane (seed_lane),
        .seed_data (seed_data),
        .draw      (bus),
        .rand_flat (rand_flat)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [LW-1:0] lane;
        logic          err;
    } rsp_t;

    rsp_t         sb [$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_state [NL];
    logic         m_pending;

    // x^13+x^4+x^3+x+1 taken straight from the polynomial exponents.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
        if (s == '0) return W'(1);
        return {s[W-2:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    function automatic logic [W-1:0] lane_of(input int i);
        return rand_flat[i*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        tick = 1'b0; seed_we = 1'b0; bus.req_valid = 1'b0;
    endtask

    task automatic do_reset();
        logic [W-1:0] rst_exp [NL];
        rst_exp = '{13'h0001, 13'h0101, 13'h0201, 13'h0301};
        idle();
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_state   = rst_exp;
        m_pending = 1'b0;
        sb.delete();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
        chk("rst_rsp_lane",  64'(bus.rsp_lane),  64'(0));
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
        for (int i = 0; i < NL; i++) chk($sformatf("rst_lane%0d", i), 64'(lane_of(i)), 64'(rst_exp[i]));
    endtask

    // One clock: check pre-edge handshake outputs, advance the model, check lane state after the edge.
    task automatic cycle();
        rsp_t         e;
        logic         ready_m, acc, hit_l;
        logic [W-1:0] nxt [NL];
        logic [63:0]  flat;
        #2;
        ready_m = !m_pending || bus.rsp_ready;
        chk("req_ready", 64'(bus.req_ready), 64'(ready_m));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_pending));
        if (m_pending) begin
            chk("sb_depth", 64'(sb.size()), 64'(1));
            if (sb.size() > 0) begin
                chk("rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
                chk("rsp_lane", 64'(bus.rsp_lane), 64'(sb[0].lane));
                chk("rsp_err",  64'(bus.rsp_err),  64'(sb[0].err));
                if (bus.rsp_ready) void'(sb.pop_front());
            end
        end
        acc   = bus.req_valid && ready_m;
        hit_l = 1'b0;
        for (int i = 0; i < NL; i++) begin
            nxt[i] = m_state[i];
            if (seed_we && seed_lane == LW'(i)) begin
                nxt[i] = (seed_data == '0) ? W'(1) : seed_data;
                if (bus.req_lane == LW'(i)) hit_l = 1'b1;
            end else if (mode ? (acc && bus.req_lane == LW'(i)) : tick) begin
                nxt[i] = ref_step(m_state[i]);
            end
        end
        if (acc) begin
            e.lane = bus.req_lane;
            if (int'(bus.req_lane) < NL) begin
                e.err  = 1'b0;
                e.data = (mode || hit_l) ? nxt[bus.req_lane] : m_state[bus.req_lane];
            end else begin
                e.err  = 1'b1;
                e.data = '0;
            end
            sb.push_back(e);
            m_pending = 1'b1;
        end else if (bus.rsp_ready) begin
            m_pending = 1'b0;
        end
        @(posedge clk); #1;
        m_state = nxt;
        flat = '0;
        for (int i = 0; i < NL; i++) flat[i*W +: W] = m_state[i];
        chk("rand_flat", 64'(rand_flat), flat);
    endtask

    initial begin
        logic [W-1:0] step_exp [3];
        logic         seen_zero, early;
        step_exp = '{13'h0003, 13'h0007, 13'h000E};
        rst = 1'b1; mode = 1'b0; seed_lane = '0; seed_data = '0; bus.req_lane = '0;
        idle();
        do_reset();

        // Free-run stepping and hold
        tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("tick_lane0", 64'(lane_of(0)), 64'(step_exp[k]));
        end
        tick = 1'b0;
        repeat (2) cycle();
        chk("hold_lane0", 64'(lane_of(0)), 64'(13'h000E));

        // Free-run draw on a tick cycle returns the pre-tick value
        bus.rsp_ready = 1'b1; tick = 1'b1; bus.req_valid = 1'b1; bus.req_lane = 3'd0;
        cycle();
        chk("m0_draw_pretick", 64'(bus.rsp_data), 64'(13'h000E));
        idle(); cycle();

        // Draw mode: each accepted draw steps lane 0, tick ignored
        do_reset();
        mode = 1'b1; bus.rsp_ready = 1'b1; tick = 1'b1;
        bus.req_valid = 1'b1; bus.req_lane = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("draw_valid", 64'(bus.rsp_valid), 64'(1));
            chk("draw_data", 64'(bus.rsp_data), 64'(step_exp[k]));
        end
        chk("draw_lane1_same", 64'(lane_of(1)), 64'(13'h0101));
        idle(); repeat (2) cycle();

        // Backpressure holds the response and deasserts req_ready
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_lane = 3'd1;
        cycle();
        chk("bp_data", 64'(bus.rsp_data), 64'(13'h0203));
        repeat (2) cycle();
        chk("bp_ready_low", 64'(bus.req_ready), 64'(0));
        chk("bp_hold", 64'(bus.rsp_data), 64'(13'h0203));
        bus.rsp_ready = 1'b1;
        cycle();
        chk("bp_next_data", 64'(bus.rsp_data), 64'(13'h0407));
        idle(); cycle();

        // Seeding: zero coerced, seed beats draw-step, out-of-range seed ignored
        seed_we = 1'b1; seed_lane = 3'd2; seed_data = '0;
        cycle();
        chk("seed_zero_lane2", 64'(lane_of(2)), 64'(1));
        seed_lane = 3'd1; seed_data = 13'h1FFF; bus.req_valid = 1'b1; bus.req_lane = 3'd1;
        cycle();
        chk("seed_draw_data", 64'(bus.rsp_data), 64'(13'h1FFF));
        chk("seed_draw_err", 64'(bus.rsp_err), 64'(0));
        chk("seed_lane1", 64'(lane_of(1)), 64'(13'h1FFF));
        seed_lane = 3'd5; seed_data = 13'h0AAA; bus.req_valid = 1'b0;
        cycle();
        mode = 1'b0; tick = 1'b1; seed_lane = 3'd3; seed_data = 13'h0123;
        bus.req_valid = 1'b1; bus.req_lane = 3'd3;
        cycle();
        chk("m0_seed_draw", 64'(bus.rsp_data), 64'(13'h0123));
        chk("m0_seed_lane3", 64'(lane_of(3)), 64'(13'h0123));
        idle(); cycle();

        // Out-of-range draws
        mode = 1'b1; bus.req_valid = 1'b1; bus.req_lane = 3'd5;
        cycle();
        chk("oor_err", 64'(bus.rsp_err), 64'(1));
        chk("oor_data", 64'(bus.rsp_data), 64'(0));
        chk("oor_lane", 64'(bus.rsp_lane), 64'(5));
        bus.req_lane = 3'd7;
        cycle();
        idle(); cycle();

        // Reset with a stalled response pending
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_lane = 3'd0;
        cycle();
        idle(); cycle();
        do_reset();

        // Mixed random traffic
        for (int n = 0; n < 400; n++) begin
            tick          = 1'($urandom_range(0, 1));
            mode          = 1'($urandom_range(0, 3) == 0);
            seed_we       = 1'($urandom_range(0, 7) == 0);
            seed_lane     = LW'($urandom_range(0, 5));
            seed_data     = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_lane  = LW'($urandom_range(0, 5));
            bus.rsp_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end

        // Full period of lane 0
        do_reset();
        mode = 1'b0; tick = 1'b1; bus.rsp_ready = 1'b1;
        seen_zero = 1'b0; early = 1'b0;
        for (int n = 0; n < 8191; n++) begin
            cycle();
            if (lane_of(0) == '0) seen_zero = 1'b1;
            if (n < 8190 && lane_of(0) == W'(1)) early = 1'b1;
        end
        chk("period_lane0", 64'(lane_of(0)), 64'(1));
        chk("never_zero", 64'(seen_zero), 64'(0));
        chk("no_early_repeat", 64'(early), 64'(0));
        idle(); cycle();
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
